div_ctrl: RTL and testbench
===========================

# div_ctrl

Sequencing controller between the CPU execute stage and the 32-cycle iterative divide engine. It accepts DIV/DIVU/MTHI/MTLO operations, launches the engine using its level-start/busy contract, and owns the HI/LO registers. It stalls the pipeline while a divide is in flight and resolves divide-by-zero and signed overflow without using the engine.

## Interface
- No parameters; BUSY_MAX fixed at 63 cycles, START_MAX fixed at 4 cycles.
- clock  in  1  rising-edge clock
- reset_n  in  1  reset, asynchronous and active-low
- op_valid  in  1  operation request from execute stage
- op_code  in  2  00 DIV (signed), 01 DIVU, 10 MTHI, 11 MTLO
- rs_val  in  32  dividend / MTHI-MTLO data
- rt_val  in  32  divisor
- flush  in  1  pipeline flush; cancels the in-flight result
- stall  out  1  high whenever state != IDLE
- hi, lo  out  32  HI (remainder), LO (quotient)
- err  out  1  sticky engine-timeout flag; cleared only by reset
- dv_start  out  1  engine start level
- dv_signed  out  1  engine sign mode (1 = signed)
- dv_dividend, dv_divisor  out  32  engine operands, registered
- dv_busy  in  1  engine busy
- dv_q, dv_r  in  32  engine quotient and remainder

## Operation
- Reset: state IDLE; stall, err, dv_start, dv_signed = 0; hi, lo, dv_dividend, dv_divisor = 0.
- Accept: op_valid && !stall && !flush in IDLE, sampled at the rising edge. While stall=1, op_valid is ignored and the requester holds the request.
- MTHI / MTLO: hi (or lo) <= rs_val at the accept edge; state stays IDLE.
- Fast path, no engine, written at the accept edge, state stays IDLE:
  - rt_val == 0, DIV or DIVU: lo <= 32'hFFFFFFFF, hi <= rs_val.
  - DIV with rs_val == 32'h80000000 and rt_val == 32'hFFFFFFFF: lo <= 32'h80000000, hi <= 0.
- Engine path: at the accept edge, dv_dividend <= rs_val, dv_divisor <= rt_val, dv_signed <= (op_code == 00), drop <= 0; go to START.
- START: dv_start = 1.
  - dv_busy sampled 1 -> BUSY.
  - START_MAX cycles without busy -> err <= 1, IDLE, no write.
- BUSY: dv_start = 0.
  - dv_busy sampled 0 -> SETTLE.
  - Busy longer than BUSY_MAX cycles -> err <= 1, IDLE, no write.
- SETTLE: one cycle for the engine result registers to update -> WRITE.
- WRITE: if !drop, lo <= dv_q and hi <= dv_r; then -> IDLE.
- Flush in START/BUSY/SETTLE/WRITE: sets drop. The engine cannot be aborted, so sequencing continues to IDLE and HI/LO are not written. stall stays high until IDLE.
- A single 6-bit cycle counter serves both watchdogs and resets on every state change.
- dv_start is never reasserted until the engine has been seen busy and then idle; this keeps the engine's first-cycle capture clean.

## Timing
- Accept at edge E0. dv_start is high E0–E2. Engine busy is sampled high at E2.
- With a 32-cycle engine: busy is sampled low at E34, SETTLE ends at E35, WRITE ends at E36.
- hi/lo are valid in the cycle after E36. stall is high for 36 cycles (E0..E36).
- Fast path and MT ops: hi/lo are valid the cycle after accept; stall never rises.
- Reset asserted mid-operation: everything returns to reset values immediately and the in-flight result is discarded. The engine must be reset by the same net.
- hi/lo change only at accept (fast path and MT ops) or at the WRITE edge.

## Test plan
- DIV rs=100, rt=7 -> stall high 36 cycles; then lo=14, hi=2.
- DIV rs=-100 (FFFFFF9C), rt=7 -> lo=FFFFFFF2 (-14), hi=FFFFFFFE (-2). DIVU rs=FFFFFFFF, rt=2 -> lo=7FFFFFFF, hi=1.
- DIV rt=0, rs=55 -> same cycle: lo=FFFFFFFF, hi=55, stall never rises. DIV 80000000 / FFFFFFFF -> lo=80000000, hi=0, stall never rises.
- MTHI 0xA5A5A5A5, then issue MTLO while a divide is busy -> MTLO not accepted until stall falls; hi=A5A5A5A5 until divide WRITE.
- flush asserted during BUSY of DIV 9/3 -> stall still falls at E36; hi/lo keep prior values.
- Engine model that never raises busy -> err=1 after 4 START cycles, state IDLE; reset_n low mid-BUSY -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - sequencing controller for the 32-cycle iterative divide engine; owns HI/LO.
module div_ctrl (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        op_valid,
  input  logic [1:0]  op_code,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        err,
  output logic        dv_start,
  output logic        dv_signed,
  output logic [31:0] dv_dividend,
  output logic [31:0] dv_divisor,
  input  logic        dv_busy,
  input  logic [31:0] dv_q,
  input  logic [31:0] dv_r
);

  typedef enum logic [2:0] {IDLE, START, BUSY, SETTLE, WRITE} state_t;

  state_t     state, state_nx;
  logic [5:0] cnt;
  logic       drop, eng_wait, timeout;
  logic       accept, is_div, zero_div, ovf, eng_op, do_write;

  assign accept   = op_valid && (state == IDLE) && !flush;
  assign is_div   = !op_code[1];
  assign zero_div = (rt_val == 32'd0);
  assign ovf      = (op_code == 2'b00) && (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);
  assign eng_op   = is_div && !zero_div && !ovf;
  assign do_write = (state == WRITE) && !drop && !flush;
  assign stall    = (state != IDLE);
  // After a busy timeout the engine may still be running; hold start low until it goes idle.
  assign dv_start = (state == START) && !eng_wait;

  always_comb begin
    state_nx = state;
    timeout  = 1'b0;
    case (state)
      IDLE:    if (accept && eng_op) state_nx = START;
      START: begin
        if (!eng_wait && dv_busy) begin
          state_nx = BUSY;
        end else if (cnt == 6'd3) begin
          state_nx = IDLE;
          timeout  = 1'b1;
        end
      end
      BUSY: begin
        if (!dv_busy) begin
          state_nx = SETTLE;
        end else if (cnt == 6'd63) begin
          state_nx = IDLE;
          timeout  = 1'b1;
        end
      end
      SETTLE:  state_nx = WRITE;
      WRITE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= 6'd0;
      drop     <= 1'b0;
      eng_wait <= 1'b0;
      err      <= 1'b0;
    end else begin
      state <= state_nx;
      if ((state_nx != state) || (eng_wait && !dv_busy)) begin
        cnt <= 6'd0;
      end else if (cnt != 6'd63) begin
        cnt <= cnt + 6'd1;
      end
      if (accept) begin
        drop <= 1'b0;
      end else if ((state != IDLE) && flush) begin
        drop <= 1'b1;
      end
      if ((state == BUSY) && timeout) begin
        eng_wait <= 1'b1;
      end else if (!dv_busy) begin
        eng_wait <= 1'b0;
      end
      if (timeout) err <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hi          <= 32'd0;
      lo          <= 32'd0;
      dv_signed   <= 1'b0;
      dv_dividend <= 32'd0;
      dv_divisor  <= 32'd0;
    end else if (accept) begin
      case (op_code)
        2'b10: hi <= rs_val;
        2'b11: lo <= rs_val;
        default: begin
          if (zero_div) begin
            lo <= 32'hFFFF_FFFF;
            hi <= rs_val;
          end else if (ovf) begin
            lo <= 32'h8000_0000;
            hi <= 32'd0;
          end else begin
            dv_dividend <= rs_val;
            dv_divisor  <= rt_val;
            dv_signed   <= (op_code == 2'b00);
          end
        end
      endcase
    end else if (do_write) begin
      lo <= dv_q;
      hi <= dv_r;
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - directed and randomized checks of div_ctrl against a 32-cycle engine model.
module tb_div_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [1:0]  op_code = 2'b00;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        flush = 1'b0;
  logic        stall, err, dv_start, dv_signed, dv_busy;
  logic [31:0] hi, lo, dv_dividend, dv_divisor, dv_q, dv_r;

  int checks = 0;
  int failures = 0;
  logic [31:0] mhi = 32'd0;
  logic [31:0] mlo = 32'd0;
  bit eng_en = 1'b1;

  div_ctrl dut (
    .clock(clock), .reset_n(reset_n), .op_valid(op_valid), .op_code(op_code),
    .rs_val(rs_val), .rt_val(rt_val), .flush(flush), .stall(stall),
    .hi(hi), .lo(lo), .err(err), .dv_start(dv_start), .dv_signed(dv_signed),
    .dv_dividend(dv_dividend), .dv_divisor(dv_divisor), .dv_busy(dv_busy),
    .dv_q(dv_q), .dv_r(dv_r)
  );

  always #5 clock = ~clock;

  function automatic void arith_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Engine: captures start while idle, busy for 32 sampled cycles, result ready as busy drops.
  int          eng_cnt;
  logic        eng_sgn;
  logic [31:0] eng_a, eng_b;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dv_busy <= 1'b0;
      dv_q    <= 32'd0;
      dv_r    <= 32'd0;
      eng_cnt <= 0;
    end else if (!dv_busy) begin
      if (dv_start && eng_en) begin
        dv_busy <= 1'b1;
        eng_cnt <= 31;
        eng_sgn <= dv_signed;
        eng_a   <= dv_dividend;
        eng_b   <= dv_divisor;
      end
    end else if (eng_cnt == 0) begin
      logic [31:0] q, r;
      arith_div(eng_sgn, eng_a, eng_b, q, r);
      dv_q    <= q;
      dv_r    <= r;
      dv_busy <= 1'b0;
    end else begin
      eng_cnt <= eng_cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Applies the architectural rules to the model HI/LO; returns expected stall length.
  function automatic int model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (op == 2'b10) begin
      mhi = a;
      return 0;
    end
    if (op == 2'b11) begin
      mlo = a;
      return 0;
    end
    if (b == 32'd0) begin
      mlo = 32'hFFFF_FFFF;
      mhi = a;
      return 0;
    end
    if (op == 2'b00 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      mlo = 32'h8000_0000;
      mhi = 32'd0;
      return 0;
    end
    arith_div(op == 2'b00, a, b, q, r);
    mlo = q;
    mhi = r;
    return 36;
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, output int n);
    @(negedge clock);
    op_valid = 1'b1;
    op_code  = op;
    rs_val   = a;
    rt_val   = b;
    @(posedge clock);
    #1 op_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      flush = (i == flush_at);
      if (!stall) begin
        flush = 1'b0;
        return;
      end
      n++;
    end
    flush = 1'b0;
    n = -1;
    checks++;
    failures++;
    $error("FAIL stall_timeout: observed stall still high expected low within 200 cycles");
  endtask

  initial begin
    int n, exp_n;
    logic [1:0]  op;
    logic [31:0] a, b;

    #12 reset_n = 1'b1;
    @(negedge clock);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_start", {31'd0, dv_start}, 32'd0);
    chk("rst_signed", {31'd0, dv_signed}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_dividend", dv_dividend, 32'd0);
    chk("rst_divisor", dv_divisor, 32'd0);

    exp_n = model_op(2'b00, 32'd100, 32'd7);
    run_op(2'b00, 32'd100, 32'd7, -1, n);
    chk("div100_7_stall", n, 36);
    chk("div100_7_lo", lo, 32'd14);
    chk("div100_7_hi", hi, 32'd2);
    chk("div100_7_sgn", {31'd0, dv_signed}, 32'd1);
    chk("div100_7_opnd", dv_dividend, 32'd100);

    exp_n = model_op(2'b00, 32'hFFFF_FF9C, 32'd7);
    run_op(2'b00, 32'hFFFF_FF9C, 32'd7, -1, n);
    chk("divneg_lo", lo, 32'hFFFF_FFF2);
    chk("divneg_hi", hi, 32'hFFFF_FFFE);

    exp_n = model_op(2'b01, 32'hFFFF_FFFF, 32'd2);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd2, -1, n);
    chk("divu_lo", lo, 32'h7FFF_FFFF);
    chk("divu_hi", hi, 32'd1);
    chk("divu_sgn", {31'd0, dv_signed}, 32'd0);

    exp_n = model_op(2'b00, 32'd55, 32'd0);
    run_op(2'b00, 32'd55, 32'd0, -1, n);
    chk("div0_stall", n, 0);
    chk("div0_lo", lo, 32'hFFFF_FFFF);
    chk("div0_hi", hi, 32'd55);

    exp_n = model_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, -1, n);
    chk("ovf_stall", n, 0);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'd0);

    // MTLO held while a divide is in flight must wait for stall to fall.
    exp_n = model_op(2'b10, 32'hA5A5_A5A5, 32'd0);
    run_op(2'b10, 32'hA5A5_A5A5, 32'd0, -1, n);
    chk("mthi_hi", hi, 32'hA5A5_A5A5);
    @(negedge clock);
    op_valid = 1'b1;
    op_code  = 2'b00;
    rs_val   = 32'd9;
    rt_val   = 32'd3;
    @(posedge clock);
    #1;
    op_code = 2'b11;
    rs_val  = 32'h1234_5678;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (i == 0) chk("mt_start", {31'd0, dv_start}, 32'd1);
      if (i == 20) chk("mt_hi_hold", hi, 32'hA5A5_A5A5);
      if (i == 20) chk("mt_lo_hold", lo, mlo);
      if (!stall) break;
      n++;
    end
    chk("mt_stall", n, 36);
    chk("mt_div_lo", lo, 32'd3);
    chk("mt_div_hi", hi, 32'd0);
    @(posedge clock);
    #1 op_valid = 1'b0;
    chk("mt_lo_late", lo, 32'h1234_5678);
    mhi = 32'd0;
    mlo = 32'h1234_5678;

    run_op(2'b00, 32'd9, 32'd3, 10, n);
    chk("flush_stall", n, 36);
    chk("flush_hi", hi, mhi);
    chk("flush_lo", lo, mlo);

    for (int k = 0; k < 12; k++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'd0;
      if ($urandom_range(0, 5) == 0) begin
        op = 2'b00;
        a  = 32'h8000_0000;
        b  = 32'hFFFF_FFFF;
      end
      if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(16, 30);
      exp_n = model_op(op, a, b);
      run_op(op, a, b, -1, n);
      chk($sformatf("rnd%0d_stall", k), n, exp_n);
      chk($sformatf("rnd%0d_hi", k), hi, mhi);
      chk($sformatf("rnd%0d_lo", k), lo, mlo);
    end

    eng_en = 1'b0;
    run_op(2'b00, 32'd10, 32'd3, -1, n);
    chk("nobusy_stall", n, 4);
    chk("nobusy_err", {31'd0, err}, 32'd1);
    chk("nobusy_hi", hi, mhi);
    chk("nobusy_lo", lo, mlo);
    eng_en = 1'b1;

    @(negedge clock);
    op_valid = 1'b1;
    op_code  = 2'b00;
    rs_val   = 32'd100;
    rt_val   = 32'd7;
    @(posedge clock);
    #1 op_valid = 1'b0;
    repeat (10) @(negedge clock);
    chk("pre_rst_stall", {31'd0, stall}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_stall", {31'd0, stall}, 32'd0);
    chk("arst_err", {31'd0, err}, 32'd0);
    chk("arst_start", {31'd0, dv_start}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    chk("arst_dividend", dv_dividend, 32'd0);
    chk("arst_divisor", dv_divisor, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    mhi = 32'd0;
    mlo = 32'd0;
    repeat (40) @(negedge clock);
    chk("post_rst_hi", hi, 32'd0);
    chk("post_rst_lo", lo, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
